dvbc_qam_demapper: RTL and testbench

Receive-side counterpart of the DVB-C QAM mapper. Takes hard-decided m-tuple symbol indices (16- to 256-QAM) from the slicer, undoes the ETSI EN 300429 differential encoding of the two MSBs, and repacks the resulting bit stream MSB-first into bytes for the downstream deinterleaver. Both sides use a valid/ready handshake.

---
 rtl/dvbc_qam_demapper.sv | 115 +++++++++++
 tb/tb_dvbc_qam_demapper.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dvbc_qam_demapper.sv
// DVB-C QAM symbol demapper: undoes the differential coding of the two MSBs
// of each m-tuple (16..256-QAM) and repacks the tuples MSB-first into bytes.
module dvbc_qam_demapper (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] qam_mode_i,
  input  logic       sync_i,
  input  logic [7:0] sym_i,
  input  logic       sym_valid_i,
  output logic       sym_ready_o,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i
);

  // Left-aligned bit buffer; valid bits are r_acc[15 -: r_cnt].
  logic [15:0] r_acc;
  logic [3:0]  r_cnt;
  logic        r_ref_i;
  logic        r_ref_q;

  logic [3:0]  w_m;
  logic [3:0]  w_shift;
  logic [7:0]  w_aligned;
  logic        w_i;
  logic        w_q;
  logic        w_ref_i;
  logic        w_ref_q;
  logic        w_d;
  logic        w_a;
  logic        w_b;
  logic [7:0]  w_tuple;
  logic        w_pop;
  logic        w_push;
  logic [15:0] w_base_acc;
  logic [3:0]  w_base_cnt;
  logic [15:0] w_ins;
  logic [15:0] w_keep;
  logic [15:0] w_acc_nxt;
  logic [3:0]  w_cnt_nxt;

  // Handshake and output view of the buffer
  assign byte_valid_o = r_cnt[3];
  assign byte_o       = r_acc[15:8];
  assign sym_ready_o  = ~r_cnt[3] | byte_ready_i;
  assign w_pop        = byte_valid_o & byte_ready_i;
  assign w_push       = sym_valid_i & sym_ready_o;

  // Bits per symbol from the runtime constellation selection
  always_comb begin
    w_m = 4'd8;
    case (qam_mode_i)
      3'd0:    w_m = 4'd4;
      3'd1:    w_m = 4'd5;
      3'd2:    w_m = 4'd6;
      3'd3:    w_m = 4'd7;
      default: w_m = 4'd8;
    endcase
  end

  // Differential decode; the symbol is left-aligned first so I/Q always sit
  // at bits 7/6 and the unused low bits fill with zeros.
  always_comb begin
    w_shift   = 4'd8 - w_m;
    w_aligned = sym_i << w_shift;
    w_i       = w_aligned[7];
    w_q       = w_aligned[6];
    w_ref_i   = sync_i ? 1'b0 : r_ref_i;
    w_ref_q   = sync_i ? 1'b0 : r_ref_q;
    w_d       = w_i ^ w_q ^ w_ref_i ^ w_ref_q;
    w_a       = w_d ? (w_i ^ w_ref_q) : (w_i ^ w_ref_i);
    w_b       = w_d ? (w_q ^ w_ref_i) : (w_q ^ w_ref_q);
    w_tuple   = {w_a, w_b, w_aligned[5:0]};
  end

  // Next buffer contents: pop first, then append the tuple behind what remains
  always_comb begin
    w_base_acc = w_pop ? {r_acc[7:0], 8'h00} : r_acc;
    if (sync_i)
      w_base_cnt = '0;
    else if (w_pop)
      w_base_cnt = r_cnt - 4'd8;
    else
      w_base_cnt = r_cnt;
    w_ins     = {w_tuple, 8'h00} >> w_base_cnt;
    w_keep    = ~(16'hFFFF >> w_base_cnt);
    w_acc_nxt = w_base_acc;
    w_cnt_nxt = w_base_cnt;
    if (w_push) begin
      w_acc_nxt = (w_base_acc & w_keep) | w_ins;
      w_cnt_nxt = w_base_cnt + w_m;
    end
  end

  // Buffer, fill count and differential reference registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ref_i <= 1'b0;
      r_ref_q <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_push) begin
        r_ref_i <= w_i;
        r_ref_q <= w_q;
      end else if (sync_i) begin
        r_ref_i <= 1'b0;
        r_ref_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dvbc_qam_demapper.sv
// Testbench for dvbc_qam_demapper: bit-queue reference model checked every
// cycle, plus directed sequences with hand-computed byte values.
module tb_dvbc_qam_demapper;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [2:0] qam_mode_i = '0;
  logic       sync_i = 1'b0;
  logic [7:0] sym_i = '0;
  logic       sym_valid_i = 1'b0;
  logic       sym_ready_o;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       byte_ready_i = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  bit        mq[$];
  bit        m_ref_i = 1'b0;
  bit        m_ref_q = 1'b0;
  logic [7:0] got_q[$];

  dvbc_qam_demapper dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .qam_mode_i  (qam_mode_i),
    .sync_i      (sync_i),
    .sym_i       (sym_i),
    .sym_valid_i (sym_valid_i),
    .sym_ready_o (sym_ready_o),
    .byte_o      (byte_o),
    .byte_valid_o(byte_valid_o),
    .byte_ready_i(byte_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bits_of(input logic [2:0] mode);
    return (mode > 3'd4) ? 8 : int'(mode) + 4;
  endfunction

  function automatic logic [7:0] front_byte();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v = {v[6:0], mq[i]};
    return v;
  endfunction

  // Reference model: predicts outputs, then applies this cycle's transfers.
  always @(negedge clk_i) begin
    if (rst_i) begin
      mq.delete();
      m_ref_i = 1'b0;
      m_ref_q = 1'b0;
      chk("rst_valid", byte_valid_o, 0);
      chk("rst_ready", sym_ready_o, 1);
      chk("rst_byte", byte_o, 0);
    end else begin
      bit exp_valid;
      bit exp_ready;
      exp_valid = (mq.size() >= 8);
      exp_ready = (mq.size() < 8) || byte_ready_i;
      chk("byte_valid", byte_valid_o, exp_valid);
      chk("sym_ready", sym_ready_o, exp_ready);
      if (exp_valid) chk("byte_o", byte_o, front_byte());
      if (exp_valid && byte_ready_i) begin
        got_q.push_back(byte_o);
        for (int i = 0; i < 8; i++) void'(mq.pop_front());
      end
      if (sync_i) begin
        mq.delete();
        m_ref_i = 1'b0;
        m_ref_q = 1'b0;
      end
      if (sym_valid_i && exp_ready) begin
        int m;
        bit i_k, q_k, a, b;
        m   = bits_of(qam_mode_i);
        i_k = sym_i[m-1];
        q_k = sym_i[m-2];
        if ((i_k ^ q_k ^ m_ref_i ^ m_ref_q) == 1'b0) begin
          a = i_k ^ m_ref_i;
          b = q_k ^ m_ref_q;
        end else begin
          a = i_k ^ m_ref_q;
          b = q_k ^ m_ref_i;
        end
        mq.push_back(a);
        mq.push_back(b);
        for (int k = m - 3; k >= 0; k--) mq.push_back(sym_i[k]);
        m_ref_i = i_k;
        m_ref_q = q_k;
      end
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    sym_valid_i = 1'b0;
    sync_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    got_q.delete();
  endtask

  // Offer one symbol and hold it until accepted (bounded)
  task automatic send(input logic [7:0] s, input logic [2:0] mode);
    bit acc = 1'b0;
    sym_i = s;
    qam_mode_i = mode;
    sym_valid_i = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk_i);
      acc = sym_ready_o;
      @(posedge clk_i); #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    sym_valid_i = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    for (int c = 0; c < 50 && got_q.size() < n; c++) @(posedge clk_i);
    #1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("byte_count", got_q.size(), n);
  endtask

  task automatic expect_bytes(input string name, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input int n);
    logic [7:0] e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    wait_bytes(n);
    for (int i = 0; i < n; i++)
      chk(name, (i < got_q.size()) ? int'(got_q[i]) : -1, int'(e[i]));
  endtask

  initial begin
    do_reset();

    // 256-QAM: 0xC5 passes through, 0x40 decodes with d=1 to 0x80
    send(8'hC5, 3'd4);
    send(8'h40, 3'd4);
    expect_bytes("qam256", 8'hC5, 8'h80, 8'h00, 2);

    // 16-QAM: 0x3, 0xA pack to 0x3A
    do_reset();
    send(8'h03, 3'd0);
    send(8'h0A, 3'd0);
    expect_bytes("qam16", 8'h3A, 8'h00, 8'h00, 1);

    // 64-QAM: four 0x0F
    do_reset();
    repeat (4) send(8'h0F, 3'd2);
    expect_bytes("qam64", 8'h3C, 8'hF3, 8'hCF, 3);

    // Backpressure hold, 256-QAM
    do_reset();
    byte_ready_i = 1'b0;
    send(8'h11, 3'd4);
    sym_i = 8'h22;
    sym_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("bp_ready", sym_ready_o, 0);
      chk("bp_valid", byte_valid_o, 1);
      chk("bp_byte", byte_o, 8'h11);
      @(posedge clk_i); #1;
    end
    byte_ready_i = 1'b1;
    send(8'h22, 3'd4);
    expect_bytes("bp", 8'h11, 8'h22, 8'h00, 2);

    // Sync discards a partial nibble and the reference
    do_reset();
    send(8'h0F, 3'd0);
    sync_i = 1'b1;
    @(posedge clk_i); #1;
    sync_i = 1'b0;
    send(8'h00, 3'd0);
    send(8'h00, 3'd0);
    expect_bytes("sync", 8'h00, 8'h00, 8'h00, 1);

    // Async reset mid-stream with a byte pending
    do_reset();
    byte_ready_i = 1'b0;
    send(8'hC5, 3'd4);
    chk("pre_rst_valid", byte_valid_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_valid", byte_valid_o, 0);
    chk("arst_ready", sym_ready_o, 1);
    chk("arst_byte", byte_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    byte_ready_i = 1'b1;
    @(posedge clk_i); #1;

    // Randomized traffic, modes, backpressure and syncs
    for (int c = 0; c < 4000; c++) begin
      sym_i        = 8'($urandom);
      qam_mode_i   = 3'($urandom_range(0, 7));
      sym_valid_i  = ($urandom_range(0, 3) != 0);
      byte_ready_i = ($urandom_range(0, 3) != 0);
      sync_i       = ($urandom_range(0, 99) == 0);
      @(posedge clk_i); #1;
    end
    sym_valid_i  = 1'b0;
    sync_i       = 1'b0;
    byte_ready_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
